// File: rtl/l1dcache_responder.sv
// rtl/l1dcache_responder.sv - direct-mapped write-through L1 data cache, core/L1D server end
// Misses nack and refill a whole line; stores go through a single-outstanding memory port.
module l1dcache_responder #(
    parameter int SETS_EXP       = 6,
    parameter int LINE_WORDS_EXP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_en,
    input  logic        core_enW,
    input  logic [29:0] core_addr,
    input  logic [3:0]  core_mask,
    input  logic [31:0] core_reqData,
    output logic [31:0] core_respData,
    output logic        core_nack,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [29:0] mem_req_addr,
    output logic [3:0]  mem_req_mask,
    output logic [31:0] mem_req_data,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        busy
);
    localparam int SETS  = 1 << SETS_EXP;
    localparam int WORDS = 1 << LINE_WORDS_EXP;
    localparam int IDX_W = SETS_EXP + LINE_WORDS_EXP;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_DATA, WRITE_REQ} state_t;
    state_t state, state_next;

    logic [31:0]               data_arr [SETS*WORDS];
    logic [TAG_W-1:0]          tag_arr  [SETS];
    logic [SETS-1:0]           valid;
    logic [LINE_WORDS_EXP-1:0] cnt;
    logic [29:0]               req_addr;
    logic [3:0]                req_mask;
    logic [31:0]               req_data;

    logic [LINE_WORDS_EXP-1:0] offset;
    logic [SETS_EXP-1:0]       set;
    logic [TAG_W-1:0]          tag;
    logic [SETS_EXP-1:0]       refill_set;
    logic [TAG_W-1:0]          refill_tag;
    logic                      hit;
    logic [31:0]               rd_word;
    logic [31:0]               merged_word;

    assign offset     = core_addr[LINE_WORDS_EXP-1:0];
    assign set        = core_addr[IDX_W-1:LINE_WORDS_EXP];
    assign tag        = core_addr[29:IDX_W];
    assign refill_set = req_addr[IDX_W-1:LINE_WORDS_EXP];
    assign refill_tag = req_addr[29:IDX_W];
    assign hit        = valid[set] && (tag_arr[set] == tag);
    assign rd_word    = data_arr[{set, offset}];

    always_comb begin
        merged_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (core_mask[b]) merged_word[8*b +: 8] = core_reqData[8*b +: 8];
        end
    end

    logic        nack_d;
    logic [31:0] resp_d;
    logic        store_merge, latch_write, latch_refill, cnt_clr, beat, fill_done;

    always_comb begin
        state_next   = state;
        nack_d       = 1'b0;
        resp_d       = '0;
        store_merge  = 1'b0;
        latch_write  = 1'b0;
        latch_refill = 1'b0;
        cnt_clr      = 1'b0;
        beat         = 1'b0;
        fill_done    = 1'b0;
        case (state)
            IDLE: begin
                if (core_en && core_enW) begin
                    store_merge = hit;
                    latch_write = 1'b1;
                    state_next  = WRITE_REQ;
                end else if (core_en) begin
                    if (hit) begin
                        resp_d = rd_word;
                    end else begin
                        nack_d       = 1'b1;
                        latch_refill = 1'b1;
                        state_next   = REFILL_REQ;
                    end
                end
            end
            WRITE_REQ: begin
                // Only load hits are served while the store is in flight.
                if (core_en) begin
                    if (!core_enW && hit) resp_d = rd_word;
                    else nack_d = 1'b1;
                end
                if (mem_req_ready) state_next = IDLE;
            end
            REFILL_REQ: begin
                nack_d = core_en;
                if (mem_req_ready) begin
                    cnt_clr    = 1'b1;
                    state_next = REFILL_DATA;
                end
            end
            REFILL_DATA: begin
                nack_d = core_en;
                if (mem_resp_valid) begin
                    beat = 1'b1;
                    if (cnt == {LINE_WORDS_EXP{1'b1}}) begin
                        fill_done  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            cnt           <= '0;
            req_addr      <= '0;
            req_mask      <= '0;
            req_data      <= '0;
            core_nack     <= 1'b0;
            core_respData <= '0;
        end else begin
            state         <= state_next;
            core_nack     <= nack_d;
            core_respData <= resp_d;
            if (latch_write) begin
                req_addr <= core_addr;
                req_mask <= core_mask;
                req_data <= core_reqData;
            end else if (latch_refill) begin
                req_addr   <= {tag, set, {LINE_WORDS_EXP{1'b0}}};
                req_mask   <= '0;
                req_data   <= '0;
                valid[set] <= 1'b0;
            end
            if (cnt_clr) cnt <= '0;
            else if (beat) cnt <= cnt + 1'b1;
            if (fill_done) valid[refill_set] <= 1'b1;
        end
    end

    // Array contents are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (store_merge) data_arr[{set, offset}] <= merged_word;
        if (beat) data_arr[{refill_set, cnt}] <= mem_resp_data;
        if (fill_done) tag_arr[refill_set] <= refill_tag;
    end

    assign mem_req_valid = (state == WRITE_REQ) || (state == REFILL_REQ);
    assign mem_req_we    = (state == WRITE_REQ);
    assign mem_req_addr  = req_addr;
    assign mem_req_mask  = req_mask;
    assign mem_req_data  = req_data;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_l1dcache_responder.sv
// tb/tb_l1dcache_responder.sv - directed and randomized bench for l1dcache_responder
module tb_l1dcache_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        core_en, core_enW;
    logic [29:0] core_addr;
    logic [3:0]  core_mask;
    logic [31:0] core_reqData;
    logic [31:0] core_respData;
    logic        core_nack;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [29:0] mem_req_addr;
    logic [3:0]  mem_req_mask;
    logic [31:0] mem_req_data;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy;

    always #5 clk = ~clk;

    l1dcache_responder dut (
        .clk(clk), .rst(rst),
        .core_en(core_en), .core_enW(core_enW), .core_addr(core_addr),
        .core_mask(core_mask), .core_reqData(core_reqData),
        .core_respData(core_respData), .core_nack(core_nack),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_mask(mem_req_mask), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: cache lines per set plus a description of the one outstanding transaction.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_data  [256];
    bit          wr_pend, rf_pend, rf_act;
    int          rf_got;
    logic [29:0] m_addr;
    logic [3:0]  m_mask;
    logic [31:0] m_wdata;
    logic        exp_nack;
    logic [31:0] exp_resp;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        wr_pend = 0; rf_pend = 0; rf_act = 0; rf_got = 0;
        exp_nack = 0; exp_resp = 0;
    endtask

    task automatic model_update(input logic en, input logic we, input logic [29:0] a,
                                input logic [3:0] mk, input logic [31:0] d,
                                input logic rdy, input logic rv, input logic [31:0] rd);
        int s, o, ls;
        int unsigned t;
        bit hit, was_wr;
        s = int'(a[7:2]); o = int'(a[1:0]); t = a[29:8];
        ls = int'(m_addr[7:2]);
        hit = m_valid[s] && (m_tag[s] == t);
        was_wr = wr_pend;
        exp_nack = 0; exp_resp = 0;
        if (rf_pend || rf_act) begin
            if (en) exp_nack = 1;
            if (rf_pend) begin
                if (rdy) begin rf_pend = 0; rf_act = 1; rf_got = 0; end
            end else if (rv) begin
                m_data[ls*4 + rf_got] = rd;
                rf_got++;
                if (rf_got == 4) begin
                    m_valid[ls] = 1; m_tag[ls] = m_addr[29:8]; rf_act = 0;
                end
            end
        end else begin
            if (en && we) begin
                if (was_wr) exp_nack = 1;
                else begin
                    if (hit) m_data[s*4 + o] = merge(m_data[s*4 + o], d, mk);
                    wr_pend = 1; m_addr = a; m_mask = mk; m_wdata = d;
                end
            end else if (en) begin
                if (hit) exp_resp = m_data[s*4 + o];
                else begin
                    exp_nack = 1;
                    if (!was_wr) begin
                        m_valid[s] = 0; m_addr = {a[29:2], 2'b00}; rf_pend = 1;
                    end
                end
            end
            if (was_wr && rdy) wr_pend = 0;
        end
    endtask

    task automatic check_outputs();
        chk("nack", core_nack, exp_nack);
        chk("resp", core_respData, exp_resp);
        chk("busy", busy, wr_pend || rf_pend || rf_act);
        chk("mreq_valid", mem_req_valid, wr_pend || rf_pend);
        if (wr_pend) begin
            chk("mreq_we", mem_req_we, 1);
            chk("mreq_waddr", mem_req_addr, m_addr);
            chk("mreq_mask", mem_req_mask, m_mask);
            chk("mreq_data", mem_req_data, m_wdata);
        end else if (rf_pend) begin
            chk("mreq_we", mem_req_we, 0);
            chk("mreq_raddr", mem_req_addr, m_addr);
        end
    endtask

    task automatic step(input logic en, input logic we, input logic [29:0] a,
                        input logic [3:0] mk, input logic [31:0] d,
                        input logic rdy, input logic rv, input logic [31:0] rd);
        check_outputs();
        core_en = en; core_enW = we; core_addr = a; core_mask = mk; core_reqData = d;
        mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_data = rd;
        model_update(en, we, a, mk, d, rdy, rv, rd);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy, input logic rv, input logic [31:0] rd);
        step(0, 0, '0, '0, '0, rdy, rv, rd);
    endtask

    task automatic fill_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) idle(0, 1, base + 32'(i));
    endtask

    task automatic do_reset();
        rst = 1;
        core_en = 0; core_enW = 0; core_addr = '0; core_mask = '0; core_reqData = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        chk("rst_nack", core_nack, 0);
        chk("rst_resp", core_respData, 0);
        chk("rst_mvalid", mem_req_valid, 0);
        chk("rst_mwe", mem_req_we, 0);
        chk("rst_maddr", mem_req_addr, 0);
        chk("rst_mmask", mem_req_mask, 0);
        chk("rst_mdata", mem_req_data, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        logic en, we, rv;
        logic [29:0] a;
        do_reset();

        // cold miss, refill, then hit
        step(1, 0, 30'h100, 0, 0, 0, 0, 0);
        chk("cold_nack", core_nack, 1);
        idle(0, 0, 0);
        chk("cold_raddr", mem_req_addr, 30'h100);
        idle(0, 0, 0);
        idle(1, 0, 0);
        fill_line(32'hDEADBE00);
        step(1, 0, 30'h102, 0, 0, 0, 0, 0);
        chk("hit_resp", core_respData, 32'hDEADBE02);

        // store hit merge
        step(1, 1, 30'h101, 4'h3, 32'hFFFF1234, 0, 0, 0);
        idle(1, 0, 0);
        step(1, 0, 30'h101, 0, 0, 0, 0, 0);
        chk("merge_resp", core_respData, 32'hDEAD1234);

        // store miss under backpressure
        step(1, 1, 30'h500, 4'hF, 32'h0BADF00D, 0, 0, 0);
        step(1, 1, 30'h504, 4'h1, 32'h11111111, 0, 0, 0);
        chk("bp_store_nack", core_nack, 1);
        step(1, 0, 30'h500, 0, 0, 0, 0, 0);
        chk("bp_load_miss_nack", core_nack, 1);
        step(1, 0, 30'h102, 0, 0, 0, 0, 0);
        chk("bp_hit_resp", core_respData, 32'hDEADBE02);
        idle(1, 0, 0);

        // mask-0 store is forwarded
        step(1, 1, 30'h0AB, 4'h0, 32'h12345678, 0, 0, 0);
        idle(1, 0, 0);

        // conflict eviction
        step(1, 0, 30'h200, 0, 0, 1, 0, 0);
        idle(1, 0, 0);
        fill_line(32'hC0DE0000);
        step(1, 0, 30'h100, 0, 0, 0, 0, 0);
        chk("evict_nack", core_nack, 1);
        chk("evict_raddr", mem_req_addr, 30'h100);
        idle(1, 0, 0);
        fill_line(32'hDEADBE00);

        // stray beats in idle
        idle(0, 1, 32'hFFFFFFFF);
        idle(0, 1, 32'hEEEEEEEE);
        chk("stray_busy", busy, 0);
        step(1, 0, 30'h102, 0, 0, 0, 0, 0);
        chk("stray_resp", core_respData, 32'hDEADBE02);

        // reset during refill
        step(1, 0, 30'h300, 0, 0, 0, 0, 0);
        idle(1, 0, 0);
        idle(0, 1, 32'hAAAA0000);
        idle(0, 1, 32'hAAAA0001);
        do_reset();
        idle(0, 1, 32'hAAAA0002);
        idle(0, 1, 32'hAAAA0003);
        chk("rst_mid_busy", busy, 0);
        step(1, 0, 30'h300, 0, 0, 0, 0, 0);
        chk("rst_mid_nack", core_nack, 1);
        step(1, 0, 30'h100, 0, 0, 0, 0, 0);
        idle(1, 0, 0);
        fill_line(32'h55550000);

        // randomized traffic over a small conflicting address pool
        for (int c = 0; c < 3000; c++) begin
            en = 1'($urandom_range(0, 1));
            we = ($urandom_range(0, 2) == 0);
            a  = 30'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 2) << 2) | $urandom_range(0, 3));
            rv = rf_act ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
            step(en, we, a, 4'($urandom), $urandom, 1'($urandom_range(0, 1)), rv, $urandom);
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
